mux_stim_seq: RTL and testbench
===============================

# mux_stim_seq

Upstream stimulus sequencer for the 2-input / 2-bit-select mux stage. On a start pulse it steps `select`, `inx` and `iny` through all 16 input combinations, holding each for a fixed dwell. It repeats this for a configured number of sweeps, then pulses `done`. Its outputs connect directly to the mux's `inx`, `iny` and `select` ports, replacing free-running testbench stimulus with a deterministic, restartable in-fabric pattern source.

## Interface
- `DWELL`, default 4: clock cycles each combination is held; legal range 1..255.
- `SWEEPS`, default 2: number of full 16-combination sweeps per run; legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low.
- `start`  in  1  run request, sampled only in IDLE.
- `stop`  in  1  abort request; priority over all other inputs.
- `hold`  in  1  freeze request; functional only with `MUX_SEQ_HOLD_EN`.
- `select`  out  2  mux select drive.
- `inx`  out  1  mux input x drive.
- `iny`  out  1  mux input y drive.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse on normal completion.
- `sweep_cnt`  out  8  completed sweeps in the current or last run.

## Operation
- Step vector V = {iny, inx, select} (4 bits). It is a 4-bit counter, so `select` cycles fastest, `inx` toggles every 4 steps and `iny` every 8 steps.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - V=0, busy=0, done=0.
  - `start`=1 and `stop`=0: go to RUN; load dwell counter with DWELL-1; clear `sweep_cnt`; V=0.
- RUN:
  - busy=1.
  - Each cycle, dwell counter decrements.
  - When the counter is 0: V increments (wraps 15->0) and the counter reloads DWELL-1.
  - On a 15->0 wrap, `sweep_cnt` increments.
  - If that wrap completes sweep number SWEEPS, go to DONE instead, with V=0.
- DONE: exactly one cycle; done=1, busy=0, V=0; then go to IDLE.
- `stop`=1 in RUN:
  - Next state is IDLE; V cleared; no `done` pulse.
  - `sweep_cnt` holds its value.
- `start` in RUN or DONE is ignored. `start` and `stop` together in IDLE keeps the block in IDLE.
- `sweep_cnt` saturates structurally: it never exceeds SWEEPS.
- Reset values: V=0, busy=0, done=0, sweep_cnt=0, state IDLE, dwell counter 0.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Start latency:
  - `start` is sampled at edge E0.
  - busy=1 and V=0 are visible after E0.
- Step rate:
  - V changes after edges E0+k·DWELL, for k = 1..16·SWEEPS-1.
  - The final expiry, at E0+16·SWEEPS·DWELL, enters DONE.
- RUN duration: exactly 16·SWEEPS·DWELL cycles.
- `done` is high for the single cycle after E0+16·SWEEPS·DWELL. `start` is accepted again from the following edge.
- DWELL=1: V advances every cycle.
- Stop: `stop` is sampled at edge Es; IDLE values are visible after Es.
- Reset mid-run: outputs clear immediately on assertion, independent of `clk`. The FSM stays in IDLE after release until a new `start`.

## Configuration
- `MUX_SEQ_HOLD_EN` defined:
  - `hold`=1 in RUN freezes the dwell counter, V and `sweep_cnt`; busy stays 1.
  - Release resumes counting from the frozen value.
  - `stop` overrides `hold`.
  - `hold` has no effect in IDLE or DONE.
- `MUX_SEQ_HOLD_EN` undefined: the `hold` port exists but is ignored. Timing is exactly as specified in the Timing section.

## Test plan
- DWELL=4, SWEEPS=2, `start` pulse at E0:
  - V reads 0,1,2,…,15,0,…,15, each value held 4 cycles.
  - `done` is high only in the cycle after E128.
  - Final `sweep_cnt`=2.
  - busy is high for exactly 128 cycles.
- Abort: `stop` asserted at E37 of the same run:
  - After E37, V=0, busy=0 and `done` never pulses.
  - `sweep_cnt`=0.
  - A subsequent `start` restarts from V=0.
- Simultaneous inputs:
  - `start`+`stop` together in IDLE: block stays in IDLE.
  - `start` pulses during RUN: no restart, and the step pattern is unchanged.
- Reset at E50 mid-run (asynchronous, between edges): all outputs are 0 before the next edge. After release with no `start`, the block remains in IDLE.
- DWELL=1, SWEEPS=1: V increments every cycle, 0..15; `done` is high in the cycle after E16.
- With `MUX_SEQ_HOLD_EN`:
  - `hold` high for 10 cycles starting at E6, with DWELL=4: V stays at 1 for 10 extra cycles.
  - Total RUN duration is 128+10 cycles.
  - Without the macro, the same stimulus gives 128 cycles.

Source files
------------

// File: rtl/mux_stim_seq.sv
//------------------------------------------------------------------------------
// mux_stim_seq
//
// Stimulus sequencer for the 2-input / 2-bit-select mux stage. A start request
// runs a 4-bit step vector V = {iny, inx, select} through all 16 combinations.
// Each value is held for DWELL cycles. This is repeated for SWEEPS full sweeps,
// and then done pulses for one cycle.
//
// Parameters
//   DWELL      cycles each combination is held (1..255)
//   SWEEPS     full 16-step sweeps per run (1..255)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous, active-low reset
//   start      run request, sampled only in IDLE
//   stop       abort request, overrides every other input
//   hold       freeze request (only active when MUX_SEQ_HOLD_EN is defined)
//   select     mux select drive (V[1:0])
//   inx        mux input x drive (V[2])
//   iny        mux input y drive (V[3])
//   busy       high while running
//   done       one-cycle pulse when a run completes normally
//   sweep_cnt  number of completed sweeps in the current or last run
//
// Optional feature macro: MUX_SEQ_HOLD_EN
//   When defined, hold=1 in RUN freezes the dwell counter, V and sweep_cnt.
//   When undefined, the hold port is present but ignored.
//
// All outputs come straight from registers.
//------------------------------------------------------------------------------
module mux_stim_seq #(
   parameter int unsigned DWELL  = 4,
   parameter int unsigned SWEEPS = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic       hold,
   output logic [1:0] select,
   output logic       inx,
   output logic       iny,
   output logic       busy,
   output logic       done,
   output logic [7:0] sweep_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] DWELL_LOAD = 8'(DWELL - 1);
   // sweep_cnt value at which the next 15->0 wrap ends the run
   localparam logic [7:0] SWEEP_LAST = 8'(SWEEPS - 1);

   state_t     state, state_nxt;
   logic [7:0] dwell_cnt, dwell_nxt;
   logic [3:0] v, v_nxt;
   logic [7:0] sweep_nxt;
   logic       busy_nxt, done_nxt;
   logic       frz;

`ifdef MUX_SEQ_HOLD_EN
   assign frz = hold;
`else
   logic unused_hold;
   assign unused_hold = hold;
   assign frz         = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         dwell_cnt <= '0;
         v         <= '0;
         sweep_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         dwell_cnt <= dwell_nxt;
         v         <= v_nxt;
         sweep_cnt <= sweep_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

   // busy and done are registered, so they are decoded from the next state
   // rather than the current state.
   always_comb begin
      state_nxt = state;
      dwell_nxt = dwell_cnt;
      v_nxt     = v;
      sweep_nxt = sweep_cnt;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;

      case (state)
         IDLE: begin
            v_nxt = '0;
            if (start && !stop) begin
               state_nxt = RUN;
               dwell_nxt = DWELL_LOAD;
               sweep_nxt = '0;
               busy_nxt  = 1'b1;
            end
         end

         RUN: begin
            busy_nxt = 1'b1;
            if (stop) begin
               // abort: sweep_cnt keeps the partial count, no done pulse
               state_nxt = IDLE;
               v_nxt     = '0;
               busy_nxt  = 1'b0;
            end else if (frz) begin
               // everything keeps its current value
            end else if (dwell_cnt == 8'd0) begin
               dwell_nxt = DWELL_LOAD;
               if (v == 4'hF) begin
                  sweep_nxt = sweep_cnt + 8'd1;
                  v_nxt     = '0;
                  if (sweep_cnt == SWEEP_LAST) begin
                     state_nxt = DONE;
                     busy_nxt  = 1'b0;
                     done_nxt  = 1'b1;
                  end
               end else begin
                  v_nxt = v + 4'd1;
               end
            end else begin
               dwell_nxt = dwell_cnt - 8'd1;
            end
         end

         DONE: begin
            state_nxt = IDLE;
            v_nxt     = '0;
         end

         default: begin
            state_nxt = IDLE;
            v_nxt     = '0;
         end
      endcase
   end

   // select changes fastest, then inx, then iny
   assign select = v[1:0];
   assign inx    = v[2];
   assign iny    = v[3];

endmodule

// File: tb/tb_mux_stim_seq.sv
//------------------------------------------------------------------------------
// tb_mux_stim_seq
//
// Directed testbench for mux_stim_seq. It uses two instances:
//   dut_a  DWELL=4, SWEEPS=2 : main run, abort, start/stop clash, reset, hold
//   dut_b  DWELL=1, SWEEPS=1 : single-cycle dwell
// Inputs change 1 time unit after a rising edge. Outputs are sampled there.
//------------------------------------------------------------------------------
module tb_mux_stim_seq;

   logic       clk;
   logic       rst_n;
   logic       start_a, stop_a, hold_a;
   logic [1:0] sel_a;
   logic       inx_a, iny_a, busy_a, done_a;
   logic [7:0] swp_a;
   logic       start_b, stop_b, hold_b;
   logic [1:0] sel_b;
   logic       inx_b, iny_b, busy_b, done_b;
   logic [7:0] swp_b;

   int n_tests = 0;
   int n_fail  = 0;

   mux_stim_seq #(.DWELL(4), .SWEEPS(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a), .hold(hold_a),
      .select(sel_a), .inx(inx_a), .iny(iny_a), .busy(busy_a), .done(done_a),
      .sweep_cnt(swp_a)
   );

   mux_stim_seq #(.DWELL(1), .SWEEPS(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b), .hold(hold_b),
      .select(sel_b), .inx(inx_b), .iny(iny_b), .busy(busy_b), .done(done_b),
      .sweep_cnt(swp_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [3:0] va();
      return {iny_a, inx_a, sel_a};
   endfunction

   function automatic logic [3:0] vb();
      return {iny_b, inx_b, sel_b};
   endfunction

   // Start is raised before edge E0. On return, the time is 1 unit after E0.
   task automatic start_run_a();
      start_a = 1'b1;
      step(1);
      start_a = 1'b0;
   endtask

   initial begin
      int  v_err, done_err, busy_cnt, k;
      bit  seen_done;

      rst_n   = 1'b0;
      start_a = 1'b0; stop_a = 1'b0; hold_a = 1'b0;
      start_b = 1'b0; stop_b = 1'b0; hold_b = 1'b0;
      step(3);
      chk("rst_v",     32'(va()),  0);
      chk("rst_busy",  32'(busy_a), 0);
      chk("rst_done",  32'(done_a), 0);
      chk("rst_sweep", 32'(swp_a),  0);
      rst_n = 1'b1;
      step(2);
      chk("idle_busy", 32'(busy_a), 0);

      // Main run. A start pulse is injected mid-run and must be ignored.
      start_run_a();
      v_err = 0; done_err = 0;
      for (int i = 0; i < 128; i++) begin
         if (va() !== 4'((i / 4) % 16)) v_err++;
         if (busy_a !== 1'b1 || done_a !== 1'b0) done_err++;
         if (i == 63) chk("sweep_before_wrap", 32'(swp_a), 0);
         if (i == 64) chk("sweep_after_wrap",  32'(swp_a), 1);
         start_a = (i == 20 || i == 21);
         step(1);
      end
      start_a = 1'b0;
      chk("run_v_pattern_errs", 32'(v_err), 0);
      chk("run_busy_done_errs", 32'(done_err), 0);
      chk("end_done",  32'(done_a), 1);
      chk("end_busy",  32'(busy_a), 0);
      chk("end_v",     32'(va()),   0);
      chk("end_sweep", 32'(swp_a),  2);
      step(1);
      chk("post_done",  32'(done_a), 0);
      chk("post_sweep", 32'(swp_a),  2);
      step(2);

      // Abort at E37
      start_run_a();
      step(36);
      stop_a = 1'b1;
      step(1);
      stop_a = 1'b0;
      chk("abort_v",     32'(va()),   0);
      chk("abort_busy",  32'(busy_a), 0);
      chk("abort_sweep", 32'(swp_a),  0);
      seen_done = 1'b0;
      for (int i = 0; i < 150; i++) begin
         if (done_a) seen_done = 1'b1;
         step(1);
      end
      chk("abort_no_done", 32'(seen_done), 0);
      start_run_a();
      chk("restart_v",    32'(va()),   0);
      chk("restart_busy", 32'(busy_a), 1);
      step(4);
      chk("restart_v_step", 32'(va()), 1);
      stop_a = 1'b1;
      step(1);
      stop_a = 1'b0;

      // start and stop together in IDLE
      start_a = 1'b1; stop_a = 1'b1;
      step(1);
      start_a = 1'b0; stop_a = 1'b0;
      chk("clash_busy", 32'(busy_a), 0);
      step(3);
      chk("clash_busy_later", 32'(busy_a), 0);
      chk("clash_v", 32'(va()), 0);

      // Asynchronous reset after E50, between edges
      start_run_a();
      step(50);
      chk("pre_reset_busy", 32'(busy_a), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("areset_v",     32'(va()),   0);
      chk("areset_busy",  32'(busy_a), 0);
      chk("areset_done",  32'(done_a), 0);
      chk("areset_sweep", 32'(swp_a),  0);
      step(2);
      rst_n = 1'b1;
      step(20);
      chk("post_reset_idle", 32'(busy_a), 0);
      chk("post_reset_v",    32'(va()),   0);

      // hold is high for 10 cycles, sampled at E6..E15
      start_run_a();
      busy_cnt = 0; seen_done = 1'b0; k = 0;
      while (k < 400 && !seen_done) begin
         if (busy_a) busy_cnt++;
         if (done_a) seen_done = 1'b1;
         if (k == 5)  hold_a = 1'b1;
         if (k == 15) hold_a = 1'b0;
`ifdef MUX_SEQ_HOLD_EN
         if (k == 17) chk("hold_v_frozen", 32'(va()), 1);
`else
         if (k == 17) chk("hold_v_ignored", 32'(va()), 4);
`endif
         if (!seen_done) step(1);
         k++;
      end
      hold_a = 1'b0;
      chk("hold_done_seen", 32'(seen_done), 1);
`ifdef MUX_SEQ_HOLD_EN
      chk("hold_busy_cycles", 32'(busy_cnt), 138);
`else
      chk("hold_busy_cycles", 32'(busy_cnt), 128);
`endif
      step(3);

      // DWELL=1, SWEEPS=1
      start_b = 1'b1;
      step(1);
      start_b = 1'b0;
      v_err = 0;
      for (int i = 0; i < 16; i++) begin
         if (vb() !== 4'(i) || busy_b !== 1'b1) v_err++;
         step(1);
      end
      chk("d1_v_pattern_errs", 32'(v_err), 0);
      chk("d1_done",  32'(done_b), 1);
      chk("d1_busy",  32'(busy_b), 0);
      chk("d1_sweep", 32'(swp_b),  1);
      step(1);
      chk("d1_done_clear", 32'(done_b), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got 0 expected 1");
      $fatal(1);
   end

endmodule
